// File: rtl/keypad_event_decoder_pkg.sv
// keypad_pkg: shared widths, key-code constants and the lowest-set-bit
// encoder used by the keypad event decoder.
// Key codes follow the scanner layout: code = 4*row + column.
// Optional feature macro used elsewhere in this slice: KEYPAD_RELEASE_EVT_EN.
package keypad_pkg;

  localparam int KEY_W  = 16;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_R0C0 = 4'd0;
  localparam logic [CODE_W-1:0] KEY_R0C1 = 4'd1;
  localparam logic [CODE_W-1:0] KEY_R0C2 = 4'd2;
  localparam logic [CODE_W-1:0] KEY_R0C3 = 4'd3;
  localparam logic [CODE_W-1:0] KEY_R1C0 = 4'd4;
  localparam logic [CODE_W-1:0] KEY_R1C1 = 4'd5;
  localparam logic [CODE_W-1:0] KEY_R1C2 = 4'd6;
  localparam logic [CODE_W-1:0] KEY_R1C3 = 4'd7;
  localparam logic [CODE_W-1:0] KEY_R2C0 = 4'd8;
  localparam logic [CODE_W-1:0] KEY_R2C1 = 4'd9;
  localparam logic [CODE_W-1:0] KEY_R2C2 = 4'd10;
  localparam logic [CODE_W-1:0] KEY_R2C3 = 4'd11;
  localparam logic [CODE_W-1:0] KEY_R3C0 = 4'd12;
  localparam logic [CODE_W-1:0] KEY_R3C1 = 4'd13;
  localparam logic [CODE_W-1:0] KEY_R3C2 = 4'd14;
  localparam logic [CODE_W-1:0] KEY_R3C3 = 4'd15;

  // Index of the lowest set bit; returns KEY_R0C0 for an all-zero vector,
  // so callers must qualify the result with |vec.
  function automatic logic [CODE_W-1:0] lowestSetBit(input logic [KEY_W-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = KEY_R0C0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_decoder_if.sv
// keypad_event_decoder_if: key-code stream from the decoder to its consumer.
//   code        head key code (0..15)
//   code_valid  head is valid
//   code_ready  consumer accepts head
//   code_rel    1 = release event (only when KEYPAD_RELEASE_EVT_EN is defined)
// master = decoder (producer), slave = display/control logic (consumer).
interface keypad_event_decoder_if;
  import keypad_pkg::*;

  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic              code_rel;
`endif

  modport master (
    input  code_ready,
    output code,
    output code_valid
`ifdef KEYPAD_RELEASE_EVT_EN
    , output code_rel
`endif
  );

  modport slave (
    output code_ready,
    input  code,
    input  code_valid
`ifdef KEYPAD_RELEASE_EVT_EN
    , input code_rel
`endif
  );

endinterface

// File: rtl/keypad_event_decoder_keycode_fifo.sv
// keycode_fifo: small show-ahead synchronous FIFO for key codes.
//   clk, rst     clock, asynchronous active-high reset
//   push_i       write pushData_i (accepted when not full, or when popping)
//   pop_i        drop head (ignored when empty)
//   full_o       no free entry
//   empty_o      no valid entry
//   popData_o    head entry, forced to 0 while empty
// Pointers carry one extra wrap bit to tell full from empty.
module keycode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] popData_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             pushDo;
  logic             popDo;

  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign popDo     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign pushDo    = push_i & (~full_o | popDo);
  assign popData_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // Pointer advance
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pushDo) wrPtr_d = wrPtr_q + 1'b1;
    if (popDo)  rdPtr_d = rdPtr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: entries are only visible between pointers
  always_ff @(posedge clk) begin
    if (pushDo) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/keypad_event_decoder.sv
// keypad_event_decoder: synchronises and debounces the 16 active-low keypad
// lines, turns press edges into 4-bit key codes and queues them.
//   clk, rst    clock, asynchronous active-high reset
//   key_raw     raw scanner vector, 0 = pressed (asynchronous)
//   pressed     debounced level, 1 = held
//   overflow    sticky: a press event merged with one still pending
//   bus         keypad_event_decoder_if.master (code/code_valid/code_ready[/code_rel])
// Optional: define KEYPAD_RELEASE_EVT_EN to also queue release events,
// widening FIFO entries with a release flag.
module keypad_event_decoder
  import keypad_pkg::*;
#(
  parameter int SAMPLE_DIV  = 50000,
  parameter int DEB_SAMPLES = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       key_raw,
  output logic [KEY_W-1:0]       pressed,
  output logic                   overflow,
  keypad_event_decoder_if.master bus
);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int FIFO_W = CODE_W + 1;
`else
  localparam int FIFO_W = CODE_W;
`endif
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [KEY_W-1:0]                  sync1_q, sync2_q;
  logic [CNT_W-1:0]                  tickCount_q;
  logic                              tick;
  logic [KEY_W-1:0][DEB_SAMPLES-1:0] hist_q, hist_d;
  logic [KEY_W-1:0]                  pressed_q, pressed_d;
  logic [KEY_W-1:0]                  pending_q, pending_d;
  logic [KEY_W-1:0]                  pressEvt, clrPress;
  logic                              overflow_q, overflow_d;
  logic                              pushReq;
  logic [FIFO_W-1:0]                 pushData;
  logic [CODE_W-1:0]                 selIdx;
  logic                              fifoFull, fifoEmpty, fifoPop;
  logic [FIFO_W-1:0]                 fifoHead;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic [KEY_W-1:0]                  rpending_q, rpending_d;
  logic [KEY_W-1:0]                  relEvt, clrRel;
`endif

  assign tick     = (tickCount_q == CNT_W'(SAMPLE_DIV - 1));
  assign pressed  = pressed_q;
  assign overflow = overflow_q;
  assign fifoPop  = ~fifoEmpty & bus.code_ready;

  // Two-flop synchroniser; idle (released) level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Sample-tick divider: tick asserted for one cycle at wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tickCount_q <= '0;
    else if (tick) tickCount_q <= '0;
    else           tickCount_q <= tickCount_q + 1'b1;
  end

  // Debounce: a key changes level only after DEB_SAMPLES agreeing samples
  always_comb begin
    logic [DEB_SAMPLES-1:0] histNext;
    histNext  = '1;
    hist_d    = hist_q;
    pressed_d = pressed_q;
    if (tick) begin
      for (int i = 0; i < KEY_W; i++) begin
        histNext  = {hist_q[i][DEB_SAMPLES-2:0], sync2_q[i]};
        hist_d[i] = histNext;
        if (histNext == '0)  pressed_d[i] = 1'b1;
        else if (&histNext)  pressed_d[i] = 1'b0;
      end
    end
  end

  assign pressEvt = pressed_d & ~pressed_q;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign relEvt   = pressed_q & ~pressed_d;
`endif

  // Encoder: one push per cycle, lowest key first, presses before releases
  always_comb begin
    pushReq  = 1'b0;
    pushData = '0;
    selIdx   = '0;
    clrPress = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
    clrRel   = '0;
`endif
    if (|pending_q) begin
      pushReq  = 1'b1;
      selIdx   = lowestSetBit(pending_q);
      pushData = FIFO_W'(selIdx);
      if (~fifoFull | fifoPop) clrPress = KEY_W'(1) << selIdx;
    end
`ifdef KEYPAD_RELEASE_EVT_EN
    else if (|rpending_q) begin
      pushReq  = 1'b1;
      selIdx   = lowestSetBit(rpending_q);
      pushData = {1'b1, selIdx};
      if (~fifoFull | fifoPop) clrRel = KEY_W'(1) << selIdx;
    end
`endif
  end

  // Pending masks; an event landing on a still-pending bit is merged and flagged
  always_comb begin
    pending_d  = (pending_q & ~clrPress) | pressEvt;
    overflow_d = overflow_q | (|(pressEvt & pending_q & ~clrPress));
`ifdef KEYPAD_RELEASE_EVT_EN
    rpending_d = (rpending_q & ~clrRel) | relEvt;
    overflow_d = overflow_d | (|(relEvt & rpending_q & ~clrRel));
`endif
  end

  // Debounce and event state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q     <= '1;
      pressed_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      rpending_q <= '0;
`endif
    end else begin
      hist_q     <= hist_d;
      pressed_q  <= pressed_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
`ifdef KEYPAD_RELEASE_EVT_EN
      rpending_q <= rpending_d;
`endif
    end
  end

  keycode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pushReq),
    .pushData_i (pushData),
    .pop_i      (fifoPop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .popData_o  (fifoHead)
  );

  assign bus.code       = fifoHead[CODE_W-1:0];
  assign bus.code_valid = ~fifoEmpty;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign bus.code_rel   = fifoHead[CODE_W];
`endif

endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb_keypad_event_decoder: directed and randomized checks of the keypad
// event decoder with SAMPLE_DIV=4, DEB_SAMPLES=4, FIFO_DEPTH=4.
// Honours KEYPAD_RELEASE_EVT_EN (release codes are drained or checked).
module tb_keypad_event_decoder;
  import keypad_pkg::*;

  localparam int SDIV = 4;
  localparam int DEB  = 4;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] key_raw;
  logic [15:0] pressed;
  logic        overflow;
  int          assertCount;
  int          failCount;

  keypad_event_decoder_if kif ();

  keypad_event_decoder #(
    .SAMPLE_DIV  (SDIV),
    .DEB_SAMPLES (DEB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .pressed  (pressed),
    .overflow (overflow),
    .bus      (kif)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] raw, input logic ready);
    key_raw        = raw;
    kif.code_ready = ready;
  endtask

  task automatic tickWait(input int n);
    repeat (n * SDIV) @(negedge clk);
  endtask

  // Wait (bounded) for a head entry, check it, then pop it
  task automatic popExpect(input string tag, input int expCode, input bit expRel);
    int c;
    c = 0;
    while (!kif.code_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_valid"}, 32'(kif.code_valid), 32'd1);
    checkOutput(tag, 32'(kif.code), 32'(expCode));
`ifdef KEYPAD_RELEASE_EVT_EN
    checkOutput({tag, "_rel"}, 32'(kif.code_rel), 32'(expRel));
`else
    if (expRel) checkOutput({tag, "_rel_unsupported"}, 32'd1, 32'd0);
`endif
    kif.code_ready = 1'b1;
    @(negedge clk);
    kif.code_ready = 1'b0;
  endtask

  // Release every key; in the release build the release codes are drained
  task automatic releaseAll(input string tag);
    applyStimulus(16'hFFFF, REL_EN);
    tickWait(12);
    kif.code_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_pressed"}, 32'(pressed), 32'd0);
    checkOutput({tag, "_nocode"}, 32'(kif.code_valid), 32'd0);
  endtask

  initial begin
    int          c;
    bit          sawValid;
    logic [15:0] mask;
    int          expQ[$];
    bit          r;

    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    applyStimulus(16'hFFFF, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_pressed", 32'(pressed), 32'd0);
    checkOutput("rst_valid", 32'(kif.code_valid), 32'd0);
    checkOutput("rst_code", 32'(kif.code), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: hold key 5; check pressed-to-valid latency, single code, no repeats
    $display("[TB] step 1: key 5 held");
    applyStimulus(~(16'd1 << 5), 1'b0);
    c = 0;
    while (!pressed[5] && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("k5_pressed", 32'(pressed), 32'h0020);
    checkOutput("k5_lat_valid_low", 32'(kif.code_valid), 32'd0);
    @(negedge clk);
    checkOutput("k5_lat_valid_high", 32'(kif.code_valid), 32'd1);
    tickWait(38);
    popExpect("k5_code", 5, 1'b0);
    checkOutput("k5_empty", 32'(kif.code_valid), 32'd0);
    sawValid = 1'b0;
    repeat (10 * SDIV) begin
      @(negedge clk);
      if (kif.code_valid) sawValid = 1'b1;
    end
    checkOutput("k5_no_repeat", 32'(sawValid), 32'd0);
    releaseAll("k5_rel");

    // 2: key 9 bouncing every tick never settles
    $display("[TB] step 2: key 9 bouncing");
    sawValid = 1'b0;
    for (int t = 0; t < 30; t++) begin
      key_raw[9] = ~key_raw[9];
      repeat (SDIV) begin
        @(negedge clk);
        if (kif.code_valid || pressed != 16'd0) sawValid = 1'b1;
      end
    end
    key_raw[9] = 1'b1;
    checkOutput("bounce_quiet", 32'(sawValid), 32'd0);

    // 3: keys 12 and 3 in the same cycle come out in ascending order
    $display("[TB] step 3: keys 12 and 3 together");
    applyStimulus(~((16'd1 << 12) | (16'd1 << 3)), 1'b0);
    tickWait(12);
    popExpect("pair_first", 3, 1'b0);
    popExpect("pair_second", 12, 1'b0);
    checkOutput("pair_empty", 32'(kif.code_valid), 32'd0);
    releaseAll("pair_rel");

    // 4: five presses into a four-deep FIFO, nothing lost
    $display("[TB] step 4: FIFO full with key 8 pending");
    applyStimulus(~16'h0117, 1'b0);
    tickWait(12);
    checkOutput("full_pressed", 32'(pressed), 32'h0117);
    popExpect("full_c0", 0, 1'b0);
    popExpect("full_c1", 1, 1'b0);
    popExpect("full_c2", 2, 1'b0);
    popExpect("full_c4", 4, 1'b0);
    popExpect("full_c8", 8, 1'b0);
    checkOutput("full_empty", 32'(kif.code_valid), 32'd0);
    checkOutput("full_overflow", 32'(overflow), 32'd0);
    releaseAll("full_rel");

    // Random key sets against an ascending-order reference with random ready
    $display("[TB] random key sets");
    for (int round = 0; round < 4; round++) begin
      mask = 16'($urandom_range(1, 65535));
      expQ.delete();
      for (int k = 0; k < 16; k++) if (mask[k]) expQ.push_back(k);
      applyStimulus(~mask, 1'b0);
      tickWait(12);
      checkOutput("rand_pressed", 32'(pressed), 32'(mask));
      c = 0;
      while (expQ.size() > 0 && c < 600) begin
        r = 1'($urandom_range(0, 1));
        if (r && kif.code_valid) checkOutput("rand_code", 32'(kif.code), 32'(expQ.pop_front()));
        kif.code_ready = r;
        @(negedge clk);
        c++;
      end
      kif.code_ready = 1'b0;
      checkOutput("rand_drained", 32'(expQ.size()), 32'd0);
      checkOutput("rand_empty", 32'(kif.code_valid), 32'd0);
      checkOutput("rand_overflow", 32'(overflow), 32'd0);
      releaseAll("rand_rel");
    end

    // 5: reset with two queued codes and key 7 pending
    $display("[TB] step 5: reset mid-operation");
    applyStimulus(~16'h000C, 1'b0);
    tickWait(12);
    checkOutput("mid_head", 32'(kif.code), 32'd2);
    key_raw[7] = 1'b0;
    c = 0;
    while (!pressed[7] && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("mid_k7_pressed", 32'(pressed[7]), 32'd1);
    rst = 1'b1;
    applyStimulus(16'hFFFF, 1'b0);
    @(negedge clk);
    checkOutput("mid_rst_pressed", 32'(pressed), 32'd0);
    checkOutput("mid_rst_valid", 32'(kif.code_valid), 32'd0);
    checkOutput("mid_rst_code", 32'(kif.code), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (20 * SDIV) begin
      @(negedge clk);
      if (kif.code_valid) sawValid = 1'b1;
    end
    checkOutput("mid_no_code", 32'(sawValid), 32'd0);

`ifdef KEYPAD_RELEASE_EVT_EN
    // 6: press then release key 14 yields a press code then a release code
    $display("[TB] step 6: release events");
    applyStimulus(~(16'd1 << 14), 1'b0);
    tickWait(12);
    popExpect("rel_press", 14, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    tickWait(12);
    popExpect("rel_release", 14, 1'b1);
    checkOutput("rel_empty", 32'(kif.code_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
